// File: rtl/palette_update_scheduler.sv
// palette_update_scheduler
// Runtime-updatable 8:8:8 palette. Host writes are queued in a small FIFO and
// committed to the palette RAM only while the display is blanking, one entry
// per clock. The pixel pipeline gets a registered lookup with read-old
// behaviour when a commit lands on the same entry in the same cycle.
// Optional feature macro: PALETTE_READBACK_EN (adds a committed-palette
// readback port with one-cycle latency).
module palette_update_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   aClock,
    input  logic                   aReset,
    input  logic                   aWriteValid,
    input  logic [INDEX_WIDTH-1:0] aWriteIndex,
    input  logic [23:0]            aWriteColor,
    output logic                   anOutWriteReady,
    input  logic                   aBlank,
    input  logic [INDEX_WIDTH-1:0] aPixelIndex,
    output logic [7:0]             anOutRed,
    output logic [7:0]             anOutGreen,
    output logic [7:0]             anOutBlue,
    output logic                   anOutPending,
`ifdef PALETTE_READBACK_EN
    input  logic                   aReadValid,
    input  logic [INDEX_WIDTH-1:0] aReadIndex,
    output logic                   anOutReadValid,
    output logic [23:0]            anOutReadColor,
`endif
    output logic [1:0]             anOutState
);

    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PAL_SIZE = 1 << INDEX_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] fifo_index [FIFO_DEPTH];
    logic [23:0]            fifo_color [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [23:0]            palette [PAL_SIZE];
    logic [23:0]            rgb_q;
    logic                   push;
    logic                   pop;
    logic                   last_pop;

    function automatic logic [23:0] default_color(input int unsigned i);
        case (i)
            0:       default_color = 24'h000000;
            1:       default_color = 24'hffffff;
            2:       default_color = 24'hff0000;
            3:       default_color = 24'h00ff00;
            4:       default_color = 24'h0000ff;
            5:       default_color = 24'hffff00;
            6:       default_color = 24'h00ffff;
            7:       default_color = 24'hff00ff;
            default: default_color = 24'h000000;
        endcase
    endfunction

    // Ready and pending come from the registered count, so a pop cannot make
    // room for a push in the same cycle.
    assign anOutWriteReady = (count != FULL_COUNT);
    assign anOutPending    = (count != '0);
    assign push            = aWriteValid && anOutWriteReady;
    assign pop             = (state == COMMIT) && aBlank;
    assign last_pop        = pop && (count == ONE_COUNT) && !push;

    // FIFO pointers and occupancy
    always_ff @(posedge aClock) begin
        if (aReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge aClock) begin
        if (push) begin
            fifo_index[wr_ptr] <= aWriteIndex;
            fifo_color[wr_ptr] <= aWriteColor;
        end
    end

    // Commit scheduler: waits for blanking, drains one entry per blank cycle
    always_ff @(posedge aClock) begin
        if (aReset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) state <= aBlank ? COMMIT : WAIT_BLANK;
                end
                WAIT_BLANK: begin
                    if (aBlank) state <= COMMIT;
                end
                COMMIT: begin
                    if (!aBlank)       state <= WAIT_BLANK;
                    else if (last_pop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Palette RAM: defaults on reset, otherwise written only by commits
    always_ff @(posedge aClock) begin
        if (aReset) begin
            for (int unsigned i = 0; i < PAL_SIZE; i++) begin
                palette[INDEX_WIDTH'(i)] <= default_color(i);
            end
        end else if (pop) begin
            palette[fifo_index[rd_ptr]] <= fifo_color[rd_ptr];
        end
    end

    // Pixel lookup; sees the palette before any same-edge commit
    always_ff @(posedge aClock) begin
        if (aReset) rgb_q <= '0;
        else        rgb_q <= palette[aPixelIndex];
    end

    assign anOutRed   = rgb_q[23:16];
    assign anOutGreen = rgb_q[15:8];
    assign anOutBlue  = rgb_q[7:0];
    assign anOutState = state;

`ifdef PALETTE_READBACK_EN
    // Host readback of committed contents; queued writes are not visible
    always_ff @(posedge aClock) begin
        if (aReset) begin
            anOutReadValid <= 1'b0;
            anOutReadColor <= '0;
        end else begin
            anOutReadValid <= aReadValid;
            anOutReadColor <= aReadValid ? palette[aReadIndex] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_palette_update_scheduler.sv
// Testbench for palette_update_scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a queue-based reference model.
// Honours PALETTE_READBACK_EN when defined.
module tb_palette_update_scheduler;

    localparam int DEPTH = 4;
    localparam int IW    = 3;

    typedef struct {
        logic [IW-1:0] idx;
        logic [23:0]   color;
    } wr_t;

    logic          clk = 1'b0;
    logic          aReset = 1'b0;
    logic          aWriteValid = 1'b0;
    logic [IW-1:0] aWriteIndex = '0;
    logic [23:0]   aWriteColor = '0;
    logic          anOutWriteReady;
    logic          aBlank = 1'b0;
    logic [IW-1:0] aPixelIndex = '0;
    logic [7:0]    anOutRed, anOutGreen, anOutBlue;
    logic          anOutPending;
    logic [1:0]    anOutState;
`ifdef PALETTE_READBACK_EN
    logic          aReadValid = 1'b0;
    logic [IW-1:0] aReadIndex = '0;
    logic          anOutReadValid;
    logic [23:0]   anOutReadColor;
    logic          rv = 1'b0;
    logic [IW-1:0] ri = '0;
    logic          exp_rd_valid;
    logic [23:0]   exp_rd_color;
`endif

    // Reference model
    wr_t         q[$];
    logic [23:0] pal [8];
    int          mst;           // 0 idle, 1 waiting for blank, 2 committing
    logic [23:0] exp_rgb;
    logic        last_push;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] defaults [8] = '{24'h000000, 24'hffffff, 24'hff0000, 24'h00ff00,
                                  24'h0000ff, 24'hffff00, 24'h00ffff, 24'hff00ff};

    palette_update_scheduler #(.FIFO_DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
        .aClock          (clk),
        .aReset          (aReset),
        .aWriteValid     (aWriteValid),
        .aWriteIndex     (aWriteIndex),
        .aWriteColor     (aWriteColor),
        .anOutWriteReady (anOutWriteReady),
        .aBlank          (aBlank),
        .aPixelIndex     (aPixelIndex),
        .anOutRed        (anOutRed),
        .anOutGreen      (anOutGreen),
        .anOutBlue       (anOutBlue),
        .anOutPending    (anOutPending),
`ifdef PALETTE_READBACK_EN
        .aReadValid      (aReadValid),
        .aReadIndex      (aReadIndex),
        .anOutReadValid  (anOutReadValid),
        .anOutReadColor  (anOutReadColor),
`endif
        .anOutState      (anOutState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic step(input logic rst, input logic wv, input logic [IW-1:0] wi,
                        input logic [23:0] wc, input logic bl, input logic [IW-1:0] px);
        int   sz;
        logic push, commit;
        wr_t  e;
        @(negedge clk);
        aReset = rst; aWriteValid = wv; aWriteIndex = wi; aWriteColor = wc;
        aBlank = bl; aPixelIndex = px;
`ifdef PALETTE_READBACK_EN
        aReadValid = rv; aReadIndex = ri;
`endif
        sz = q.size();
        last_push = 1'b0;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 8; i++) pal[i] = defaults[i];
            mst = 0;
            exp_rgb = '0;
`ifdef PALETTE_READBACK_EN
            exp_rd_valid = 1'b0; exp_rd_color = '0;
`endif
        end else begin
            push   = wv && (sz < DEPTH);
            commit = (mst == 2) && bl;
            exp_rgb = pal[px];
`ifdef PALETTE_READBACK_EN
            exp_rd_valid = rv;
            exp_rd_color = rv ? pal[ri] : 24'h0;
`endif
            if (commit) begin
                e = q.pop_front();
                pal[e.idx] = e.color;
            end
            if (push) begin
                e.idx = wi; e.color = wc;
                q.push_back(e);
            end
            last_push = push;
            case (mst)
                0: if (sz != 0) mst = bl ? 2 : 1;
                1: if (bl) mst = 2;
                default: begin
                    if (!bl) mst = 1;
                    else if (sz == 1 && !push) mst = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        check("rgb", {8'h0, anOutRed, anOutGreen, anOutBlue}, {8'h0, exp_rgb});
        check("state", {30'h0, anOutState}, mst);
        check("pending", {31'h0, anOutPending}, {31'h0, q.size() != 0});
        check("ready", {31'h0, anOutWriteReady}, {31'h0, q.size() < DEPTH});
`ifdef PALETTE_READBACK_EN
        check("rd_valid", {31'h0, anOutReadValid}, {31'h0, exp_rd_valid});
        if (exp_rd_valid) check("rd_color", {8'h0, anOutReadColor}, {8'h0, exp_rd_color});
`endif
    endtask

    task automatic idle_step(input logic bl);
        step(1'b0, 1'b0, '0, '0, bl, IW'($urandom));
    endtask

    initial begin
        int k;
        logic [23:0] cols [5];

        // Reset state and default palette sweep
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        check("reset_rgb", {8'h0, anOutRed, anOutGreen, anOutBlue}, 32'h0);
        check("reset_ready", {31'h0, anOutWriteReady}, 32'h1);
        check("reset_pending", {31'h0, anOutPending}, 32'h0);
        for (int p = 0; p < 8; p++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, IW'(p));
            check("default_sweep", {8'h0, anOutRed, anOutGreen, anOutBlue}, {8'h0, defaults[p]});
        end

        // Single write deferred until blanking
        step(1'b0, 1'b1, 3'd2, 24'h123456, 1'b0, 3'd2);
        idle_step(1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 3'd2);
        check("wait_state", {30'h0, anOutState}, 32'd1);
        check("old_color", {8'h0, anOutRed, anOutGreen, anOutBlue}, 32'hff0000);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, '0, '0, 1'b1, 3'd2);
        check("new_color", {8'h0, anOutRed, anOutGreen, anOutBlue}, 32'h123456);
        check("idle_after", {30'h0, anOutState}, 32'd0);
        check("drained", {31'h0, anOutPending}, 32'h0);

        // Five back-to-back writes into a four-deep queue, fifth held by host
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cols[i] = 24'($urandom);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1, IW'(k), cols[k], 1'b0, IW'($urandom));
            if (last_push) k++;
        end
        check("accepted4", k, 32'd4);
        check("full_ready", {31'h0, anOutWriteReady}, 32'h0);
        for (int c = 0; c < 10 && k < 5; c++) begin
            step(1'b0, 1'b1, IW'(k), cols[k], 1'b1, IW'($urandom));
            if (last_push) k++;
        end
        check("accepted5", k, 32'd5);
        for (int c = 0; c < 8; c++) idle_step(1'b1);
        for (int p = 0; p < 5; p++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, IW'(p));
            check("burst_commit", {8'h0, anOutRed, anOutGreen, anOutBlue}, {8'h0, cols[p]});
        end

        // Partial drain: blanking ends with two entries still queued
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, IW'(i + 4), 24'($urandom), 1'b0, '0);
        idle_step(1'b0);
        for (int c = 0; c < 3; c++) idle_step(1'b1);
        idle_step(1'b0);
        check("partial_state", {30'h0, anOutState}, 32'd1);
        check("partial_pending", {31'h0, anOutPending}, 32'h1);
        for (int c = 0; c < 4; c++) idle_step(1'b1);
        check("partial_done", {31'h0, anOutPending}, 32'h0);

        // Reset while committing restores defaults and empties the queue
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 1; i < 4; i++) step(1'b0, 1'b1, IW'(i), 24'($urandom), 1'b1, '0);
        check("mid_commit", {30'h0, anOutState}, 32'd2);
        step(1'b1, 1'b0, '0, '0, 1'b1, '0);
        check("rst_state", {30'h0, anOutState}, 32'd0);
        check("rst_pending", {31'h0, anOutPending}, 32'h0);
        for (int p = 0; p < 8; p++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, IW'(p));
            check("rst_defaults", {8'h0, anOutRed, anOutGreen, anOutBlue}, {8'h0, defaults[p]});
        end

`ifdef PALETTE_READBACK_EN
        // Readback of a committed entry
        step(1'b0, 1'b1, 3'd7, 24'habcdef, 1'b1, '0);
        for (int c = 0; c < 3; c++) idle_step(1'b1);
        rv = 1'b1; ri = 3'd7;
        idle_step(1'b0);
        rv = 1'b0;
        check("readback_valid", {31'h0, anOutReadValid}, 32'h1);
        check("readback_color", {8'h0, anOutReadColor}, 32'habcdef);
        idle_step(1'b0);
        check("readback_pulse", {31'h0, anOutReadValid}, 32'h0);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
`ifdef PALETTE_READBACK_EN
            rv = 1'($urandom);
            ri = IW'($urandom);
`endif
            step(($urandom_range(0, 99) == 0), 1'($urandom), IW'($urandom), 24'($urandom),
                 ($urandom_range(0, 2) != 0), IW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
